// File: rtl/debug_reg_dump_if.sv
// debug_reg_dump_if: start/status, register-file debug read port and byte stream of debug_reg_dump
interface debug_reg_dump_if #(
  parameter int REGS  = 5,
  parameter int NBITS = 32
);
  logic             i_Start;
  logic [REGS-1:0]  o_RegDebug;
  logic [NBITS-1:0] i_DatoDebug;
  logic             o_TxValid;
  logic             i_TxReady;
  logic [7:0]       o_TxDato;
  logic             o_Busy;
  logic             o_Done;
  modport master (
    input  i_Start, i_DatoDebug, i_TxReady,
    output o_RegDebug, o_TxValid, o_TxDato, o_Busy, o_Done
  );
  modport slave (
    output i_Start, i_DatoDebug, i_TxReady,
    input  o_RegDebug, o_TxValid, o_TxDato, o_Busy, o_Done
  );
endinterface

// File: rtl/debug_reg_dump.sv
// debug_reg_dump: walks register indices 0..CELDAS-1 and streams each value LSB-first as bytes; DEBUG_DUMP_HEADER_EN prepends an 8'hA5 header byte
module debug_reg_dump #(
  parameter int REGS   = 5,
  parameter int NBITS  = 32,
  parameter int CELDAS = 32
) (
  input logic               i_clk,
  input logic               i_reset,
  debug_reg_dump_if.master  bus
);
  localparam int NB = NBITS / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
`ifdef DEBUG_DUMP_HEADER_EN
  typedef enum logic [2:0] {IDLE, HDR, LOAD, SEND, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif
  state_t           state_q, state_d;
  logic [REGS-1:0]  idx_q, idx_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // state, index, captured word and byte position
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end
  // sequencing: start, optional header, capture one register, drain its bytes, advance or finish
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.i_Start) begin
        idx_d = '0;
`ifdef DEBUG_DUMP_HEADER_EN
        state_d = HDR;
`else
        state_d = LOAD;
`endif
      end
`ifdef DEBUG_DUMP_HEADER_EN
      HDR: state_d = bus.i_TxReady ? LOAD : HDR;
`endif
      LOAD: begin
        shift_d = bus.i_DatoDebug;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: if (bus.i_TxReady) begin
        if (cnt_q != CW'(NB - 1)) begin
          shift_d = shift_q >> 8;
          cnt_d   = cnt_q + 1'b1;
        end else if (idx_q == REGS'(CELDAS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`ifdef DEBUG_DUMP_HEADER_EN
  assign bus.o_TxValid = (state_q == SEND) || (state_q == HDR);
  assign bus.o_TxDato  = (state_q == HDR) ? 8'hA5 : shift_q[7:0];
`else
  assign bus.o_TxValid = state_q == SEND;
  assign bus.o_TxDato  = shift_q[7:0];
`endif
  assign bus.o_RegDebug = idx_q;
  assign bus.o_Busy     = state_q != IDLE;
  assign bus.o_Done     = state_q == DONE;
endmodule
